// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request front-end: address field widths,
// default bus widths, the request record and the issue FSM state type.
package sdram_pkg;

   localparam int COL_WIDTH  = 9;
   localparam int ROW_WIDTH  = 12;
   localparam int BANK_WIDTH = 2;

   localparam int DEFAULT_FPGA_ADDR_WIDTH = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;
   localparam int DEFAULT_FPGA_DATA_WIDTH = 32;

   // Outstanding-read counter width; covers the 1..15 limit range.
   localparam int RD_OUT_WIDTH = 4;

   typedef struct packed {
      logic [DEFAULT_FPGA_ADDR_WIDTH-1:0] addr;
      logic                               wr_en;
      logic [DEFAULT_FPGA_DATA_WIDTH-1:0] wr_data;
   } sdram_req_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } issue_state_t;

   function automatic logic [DEFAULT_FPGA_ADDR_WIDTH-1:0] pack_addr(
      input logic [BANK_WIDTH-1:0] bank,
      input logic [ROW_WIDTH-1:0]  row,
      input logic [COL_WIDTH-1:0]  col
   );
      return {bank, row, col};
   endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous request FIFO: array storage, wrap-around pointers and an
// occupancy count. The head entry is read combinationally from the array.
module sdram_req_fifo
   import sdram_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = sdram_req_t
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  T                       i_push_data,
   input  logic                   i_pop,
   output T                       o_head,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);

   localparam int            AW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

   T              r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_full;
   logic          w_push;
   logic          w_pop;

   assign w_full  = (r_count == DEPTH_C);
   assign w_push  = i_push && !w_full;
   assign w_pop   = i_pop && (r_count != '0);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;
   assign o_empty = (r_count == '0);

endmodule

// File: rtl/sdram_req_queue.sv
// Host-side request queue in front of sdram_controller: FIFO, req/ack issue
// FSM, outstanding-read tracking and read return. SDRAM_REQ_QUEUE_BYPASS_EN
// lets a request skip the empty FIFO straight into the output register.
module sdram_req_queue
   import sdram_pkg::*;
#(
   parameter int FPGA_ADDR_WIDTH    = DEFAULT_FPGA_ADDR_WIDTH,
   parameter int FPGA_DATA_WIDTH    = DEFAULT_FPGA_DATA_WIDTH,
   parameter int DEPTH              = 4,
   parameter int MAX_RD_OUTSTANDING = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       host_valid,
   output logic                       host_ready,
   input  logic [FPGA_ADDR_WIDTH-1:0] host_addr,
   input  logic                       host_wr_en,
   input  logic [FPGA_DATA_WIDTH-1:0] host_wr_data,
   output logic                       host_rd_valid,
   output logic [FPGA_DATA_WIDTH-1:0] host_rd_data,
   output logic                       ctrl_req,
   output logic [FPGA_ADDR_WIDTH-1:0] ctrl_addr,
   output logic                       ctrl_wr_en,
   output logic [FPGA_DATA_WIDTH-1:0] ctrl_wr_data,
   input  logic                       ctrl_ack,
   input  logic                       ctrl_rd_valid,
   input  logic [FPGA_DATA_WIDTH-1:0] ctrl_rd_data,
   output logic                       rd_underflow
);

   typedef struct packed {
      logic [FPGA_ADDR_WIDTH-1:0] addr;
      logic                       wr_en;
      logic [FPGA_DATA_WIDTH-1:0] wr_data;
   } req_t;

   localparam int                      CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]           DEPTH_C = CW'(DEPTH);
   localparam logic [RD_OUT_WIDTH-1:0] RD_MAX  = RD_OUT_WIDTH'(MAX_RD_OUTSTANDING);

   issue_state_t               r_state;
   logic                       r_ready_en;
   logic                       r_req;
   logic [FPGA_ADDR_WIDTH-1:0] r_addr;
   logic                       r_wr_en;
   logic [FPGA_DATA_WIDTH-1:0] r_wr_data;
   logic [RD_OUT_WIDTH-1:0]    r_rd_out;
   logic                       r_rd_valid;
   logic [FPGA_DATA_WIDTH-1:0] r_rd_data;
   logic                       r_underflow;

   req_t                       w_push_req;
   req_t                       w_head;
   req_t                       w_issue_req;
   logic [CW-1:0]              w_fifo_count;
   logic                       w_fifo_empty;
   logic                       w_push;
   logic                       w_fifo_push;
   logic                       w_rd_room;
   logic                       w_pop;
   logic                       w_bypass;
   logic                       w_issue;
   logic                       w_rd_inc;

   // r_ready_en keeps host_ready low through reset and releases it one cycle later.
   assign host_ready = r_ready_en && (w_fifo_count < DEPTH_C);
   assign w_push     = host_valid && host_ready;
   assign w_rd_room  = (r_rd_out < RD_MAX);

   always_comb begin
      w_push_req         = '0;
      w_push_req.addr    = host_addr;
      w_push_req.wr_en   = host_wr_en;
      w_push_req.wr_data = host_wr_data;
   end

   // A read at the head that has no room blocks everything behind it.
   assign w_pop = (r_state == S_IDLE) && !w_fifo_empty && (w_head.wr_en || w_rd_room);

`ifdef SDRAM_REQ_QUEUE_BYPASS_EN
   assign w_bypass = w_push && w_fifo_empty && (r_state == S_IDLE) && (host_wr_en || w_rd_room);
`else
   assign w_bypass = 1'b0;
`endif

   assign w_fifo_push = w_push && !w_bypass;
   assign w_issue     = w_pop || w_bypass;
   assign w_issue_req = w_pop ? w_head : w_push_req;
   assign w_rd_inc    = (r_state == S_REQ) && ctrl_ack && !r_wr_en;

   sdram_req_fifo #(
      .DEPTH (DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_fifo_push),
      .i_push_data (w_push_req),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_fifo_count),
      .o_empty     (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_req     <= 1'b0;
         r_addr    <= '0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_addr    <= w_issue_req.addr;
                  r_wr_en   <= w_issue_req.wr_en;
                  r_wr_data <= w_issue_req.wr_data;
                  r_req     <= 1'b1;
                  r_state   <= S_REQ;
               end
            end
            S_REQ: begin
               if (ctrl_ack) begin
                  r_req   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_req   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // A return with nothing outstanding is flagged but never wraps the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_out    <= '0;
         r_underflow <= 1'b0;
      end else begin
         case ({w_rd_inc, ctrl_rd_valid})
            2'b10:   r_rd_out <= r_rd_out + 1'b1;
            2'b01:   r_rd_out <= (r_rd_out != '0) ? r_rd_out - 1'b1 : r_rd_out;
            default: r_rd_out <= r_rd_out;
         endcase
         if (ctrl_rd_valid && (r_rd_out == '0)) begin
            r_underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= ctrl_rd_valid;
         r_rd_data  <= ctrl_rd_data;
      end
   end

   assign ctrl_req      = r_req;
   assign ctrl_addr     = r_addr;
   assign ctrl_wr_en    = r_wr_en;
   assign ctrl_wr_data  = r_wr_data;
   assign host_rd_valid = r_rd_valid;
   assign host_rd_data  = r_rd_data;
   assign rd_underflow  = r_underflow;

endmodule

// File: tb/tb_sdram_req_queue.sv
// Scoreboard bench for sdram_req_queue: stimulus queues expected controller
// requests and read returns, negedge monitors pop and compare them.
module tb_sdram_req_queue;
   import sdram_pkg::*;

   localparam int AW    = 23;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int MAXRD = 2;
`ifdef SDRAM_REQ_QUEUE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic [AW-1:0] host_addr = '0;
   logic          host_wr_en = 1'b0;
   logic [DW-1:0] host_wr_data = '0;
   logic          host_rd_valid;
   logic [DW-1:0] host_rd_data;
   logic          ctrl_req;
   logic [AW-1:0] ctrl_addr;
   logic          ctrl_wr_en;
   logic [DW-1:0] ctrl_wr_data;
   logic          ctrl_ack = 1'b0;
   logic          ctrl_rd_valid = 1'b0;
   logic [DW-1:0] ctrl_rd_data = '0;
   logic          rd_underflow;

   always #5 clk = ~clk;

   sdram_req_queue #(
      .FPGA_ADDR_WIDTH    (AW),
      .FPGA_DATA_WIDTH    (DW),
      .DEPTH              (DEPTH),
      .MAX_RD_OUTSTANDING (MAXRD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .host_valid    (host_valid),
      .host_ready    (host_ready),
      .host_addr     (host_addr),
      .host_wr_en    (host_wr_en),
      .host_wr_data  (host_wr_data),
      .host_rd_valid (host_rd_valid),
      .host_rd_data  (host_rd_data),
      .ctrl_req      (ctrl_req),
      .ctrl_addr     (ctrl_addr),
      .ctrl_wr_en    (ctrl_wr_en),
      .ctrl_wr_data  (ctrl_wr_data),
      .ctrl_ack      (ctrl_ack),
      .ctrl_rd_valid (ctrl_rd_valid),
      .ctrl_rd_data  (ctrl_rd_data),
      .rd_underflow  (rd_underflow)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          wr_en;
      logic [DW-1:0] data;
   } exp_req_t;

   exp_req_t      exp_req[$];
   logic [DW-1:0] exp_rd[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic          prev_req = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s = 0x%0h", name, act);
      end
   endtask

   // Monitors: a new request is a rising ctrl_req; a read return is host_rd_valid.
   always @(negedge clk) begin
      exp_req_t      e;
      logic [DW-1:0] d;
      if (ctrl_req && !prev_req) begin
         if (exp_req.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got request addr 0x%0h, required none", ctrl_addr);
         end else begin
            e = exp_req.pop_front();
            chk("req_addr", {41'd0, ctrl_addr}, {41'd0, e.addr});
            chk("req_wr_en", {63'd0, ctrl_wr_en}, {63'd0, e.wr_en});
            if (e.wr_en) chk("req_wr_data", {32'd0, ctrl_wr_data}, {32'd0, e.data});
         end
      end
      if (host_rd_valid) begin
         if (exp_rd.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rd_unexpected: got read data 0x%0h, required none", host_rd_data);
         end else begin
            d = exp_rd.pop_front();
            chk("rd_data", {32'd0, host_rd_data}, {32'd0, d});
         end
      end
      prev_req = ctrl_req;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_push(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                             input bit acc);
      exp_req_t e;
      host_valid   = 1'b1;
      host_addr    = a;
      host_wr_en   = w;
      host_wr_data = d;
      chk("push_ready", {63'd0, host_ready}, {63'd0, acc});
      if (acc) begin
         e.addr  = a;
         e.wr_en = w;
         e.data  = d;
         exp_req.push_back(e);
      end
      tick();
      host_valid = 1'b0;
   endtask

   task automatic serve(input int lat);
      int w = 0;
      while (!ctrl_req && w < 50) begin
         tick();
         w++;
      end
      n_checks++;
      if (!ctrl_req) begin
         n_fail++;
         $display("FAIL serve_timeout: ctrl_req=0 after 50 cycles, required 1");
         return;
      end
      repeat (lat) tick();
      ctrl_ack = 1'b1;
      tick();
      ctrl_ack = 1'b0;
   endtask

   task automatic rd_return(input logic [DW-1:0] d);
      ctrl_rd_valid = 1'b1;
      ctrl_rd_data  = d;
      exp_rd.push_back(d);
      tick();
      ctrl_rd_valid = 1'b0;
      chk("rd_latency_valid", {63'd0, host_rd_valid}, 64'd1);
      chk("rd_latency_data", {32'd0, host_rd_data}, {32'd0, d});
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_host_ready"}, {63'd0, host_ready}, 64'd0);
      chk({tag, "_ctrl_req"}, {63'd0, ctrl_req}, 64'd0);
      chk({tag, "_ctrl_addr"}, {41'd0, ctrl_addr}, 64'd0);
      chk({tag, "_ctrl_wr_en"}, {63'd0, ctrl_wr_en}, 64'd0);
      chk({tag, "_ctrl_wr_data"}, {32'd0, ctrl_wr_data}, 64'd0);
      chk({tag, "_rd_valid"}, {63'd0, host_rd_valid}, 64'd0);
      chk({tag, "_rd_data"}, {32'd0, host_rd_data}, 64'd0);
      chk({tag, "_underflow"}, {63'd0, rd_underflow}, 64'd0);
      chk({tag, "_fifo_count"}, 64'(dut.u_fifo.r_count), 64'd0);
      chk({tag, "_rd_out"}, 64'(dut.r_rd_out), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      tick();
      tick();
      chk_outputs_zero("reset");
      reset = 1'b0;
      tick();
      chk("ready_after_reset", {63'd0, host_ready}, 64'd1);

      // Single write, ack three cycles after req rises
      drive_push(23'h12_3456, 1'b1, 32'hDEAD_BEEF, 1'b1);
      chk("wr_req_n1", {63'd0, ctrl_req}, {63'd0, BYPASS});
      chk("wr_fifo_count_n1", 64'(dut.u_fifo.r_count), BYPASS ? 64'd0 : 64'd1);
      tick();
      chk("wr_req_n2", {63'd0, ctrl_req}, 64'd1);
      repeat (BYPASS ? 2 : 3) tick();
      chk("wr_req_before_ack", {63'd0, ctrl_req}, 64'd1);
      ctrl_ack = 1'b1;
      tick();
      ctrl_ack = 1'b0;
      chk("wr_req_drop", {63'd0, ctrl_req}, 64'd0);
      chk("wr_rd_out", 64'(dut.r_rd_out), 64'd0);

      // Fill: one request issues, four fill the FIFO, the sixth is refused
      for (int i = 0; i < 5; i++) begin
         drive_push(23'h01_0000 + 23'(i), 1'b1, 32'hC0DE_0000 + 32'(i), 1'b1);
      end
      chk("fill_ready", {63'd0, host_ready}, 64'd0);
      chk("fill_count", 64'(dut.u_fifo.r_count), 64'd4);
      drive_push(23'h01_00FF, 1'b1, 32'hBAD0_BAD0, 1'b0);
      serve(0);
      chk("full_pop_ready_low", {63'd0, host_ready}, 64'd0);
      tick();
      chk("full_pop_ready_rise", {63'd0, host_ready}, 64'd1);
      for (int i = 0; i < 4; i++) serve(0);
      tick();
      chk("drain_count", 64'(dut.u_fifo.r_count), 64'd0);

      // Read limit of two outstanding reads
      drive_push(pack_addr(2'd1, 12'h010, 9'h000), 1'b0, '0, 1'b1);
      drive_push(pack_addr(2'd1, 12'h010, 9'h001), 1'b0, '0, 1'b1);
      drive_push(pack_addr(2'd1, 12'h010, 9'h002), 1'b0, '0, 1'b1);
      serve(0);
      serve(0);
      repeat (6) tick();
      chk("rdlim_blocked_req", {63'd0, ctrl_req}, 64'd0);
      chk("rdlim_rd_out", 64'(dut.r_rd_out), 64'd2);
      chk("rdlim_fifo_count", 64'(dut.u_fifo.r_count), 64'd1);
      rd_return(32'hA5A5_A5A5);
      tick();
      chk("rdlim_third_issued", {63'd0, ctrl_req}, 64'd1);
      serve(0);
      rd_return(32'h1111_1111);
      rd_return(32'h2222_2222);
      chk("rdlim_rd_out_zero", 64'(dut.r_rd_out), 64'd0);
      chk("rdlim_no_underflow", {63'd0, rd_underflow}, 64'd0);

      // Underflow: the word is still forwarded, counter stays at zero
      rd_return(32'h5A5A_0001);
      chk("underflow_set", {63'd0, rd_underflow}, 64'd1);
      chk("underflow_rd_out", 64'(dut.r_rd_out), 64'd0);
      repeat (3) tick();
      chk("underflow_sticky", {63'd0, rd_underflow}, 64'd1);

      // Reset with one request in flight and three queued
      for (int i = 0; i < 4; i++) begin
         drive_push(23'h02_0000 + 23'(i), 1'b1, 32'h0BAD_0000 + 32'(i), 1'b1);
      end
      chk("midrst_req_high", {63'd0, ctrl_req}, 64'd1);
      chk("midrst_queued", 64'(dut.u_fifo.r_count), 64'd3);
      exp_req.delete();
      reset = 1'b1;
      tick();
      chk_outputs_zero("midrst");
      reset = 1'b0;
      repeat (10) tick();
      chk("midrst_no_issue", {63'd0, ctrl_req}, 64'd0);
      chk("midrst_ready", {63'd0, host_ready}, 64'd1);
      drive_push(23'h03_0001, 1'b1, 32'h600D_F00D, 1'b1);
      serve(1);
      tick();

      chk("scoreboard_req_empty", 64'(exp_req.size()), 64'd0);
      chk("scoreboard_rd_empty", 64'(exp_rd.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
